// File: rtl/alu_exec_unit_if.sv
// Issue/result bus between the EX-stage issue logic and the ALU execute unit.
// Issue side drives operands and control; the ALU returns ready and the result strobe.
interface alu_exec_unit_if #(
   parameter int WIDTH = 32
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       alu_ctl;
   logic             sign;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             overflow;

   modport master (
      output flush, in_valid, alu_ctl, sign, op_a, op_b,
      input  in_ready, out_valid, result, zero, overflow
   );

   modport slave (
      input  flush, in_valid, alu_ctl, sign, op_a, op_b,
      output in_ready, out_valid, result, zero, overflow
   );
endinterface

// File: rtl/alu_exec_unit.sv
// MIPS execute-stage ALU: single-cycle arithmetic/logic with a registered result,
// plus an optional one-bit-per-cycle shifter that stalls issue while it runs.
module alu_exec_unit #(
   parameter int WIDTH        = 32,
   parameter bit SERIAL_SHIFT = 1'b1
) (
   input  logic         clk,
   input  logic         reset_n,
   alu_exec_unit_if.slave bus
);
   localparam logic [4:0] C_AND = 5'b00000;
   localparam logic [4:0] C_OR  = 5'b00001;
   localparam logic [4:0] C_ADD = 5'b00010;
   localparam logic [4:0] C_SUB = 5'b00110;
   localparam logic [4:0] C_SLT = 5'b00111;
   localparam logic [4:0] C_NOR = 5'b01100;
   localparam logic [4:0] C_XOR = 5'b01101;
   localparam logic [4:0] C_SLL = 5'b10000;
   localparam logic [4:0] C_SRL = 5'b11000;
   localparam logic [4:0] C_SRA = 5'b11001;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [4:0]       r_cnt;
   logic [4:0]       r_sctl;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_ovf;
   logic             r_valid;

   logic             w_accept;
   logic             w_is_shift;
   logic             w_serial;
   logic [4:0]       w_shamt;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic             w_lt;
   logic [WIDTH-1:0] w_res;
   logic             w_ovf;
   logic [WIDTH-1:0] w_step;

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = r_valid;
   assign bus.result    = r_result;
   assign bus.zero      = r_zero;
   assign bus.overflow  = r_ovf;

   assign w_accept   = bus.in_valid & bus.in_ready & ~bus.flush;
   assign w_shamt    = bus.op_a[4:0];
   assign w_is_shift = (bus.alu_ctl == C_SLL) | (bus.alu_ctl == C_SRL) | (bus.alu_ctl == C_SRA);
   // A zero shift amount has nothing to iterate, so it completes like any single-cycle op.
   assign w_serial   = SERIAL_SHIFT & w_is_shift & (w_shamt != 5'd0);
   assign w_sum      = bus.op_a + bus.op_b;
   assign w_diff     = bus.op_a - bus.op_b;
   assign w_lt       = bus.sign ? ($signed(bus.op_a) < $signed(bus.op_b)) : (bus.op_a < bus.op_b);

   always_comb begin
      w_res = '0;
      w_ovf = 1'b0;
      case (bus.alu_ctl)
         C_ADD: begin
            w_res = w_sum;
            w_ovf = bus.sign & (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &
                    (w_sum[WIDTH-1] != bus.op_a[WIDTH-1]);
         end
         C_SUB: begin
            w_res = w_diff;
            w_ovf = bus.sign & (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &
                    (w_diff[WIDTH-1] != bus.op_a[WIDTH-1]);
         end
         C_AND:   w_res = bus.op_a & bus.op_b;
         C_OR:    w_res = bus.op_a | bus.op_b;
         C_XOR:   w_res = bus.op_a ^ bus.op_b;
         C_NOR:   w_res = ~(bus.op_a | bus.op_b);
         C_SLT:   w_res = {{(WIDTH-1){1'b0}}, w_lt};
         C_SLL:   w_res = bus.op_b << w_shamt;
         C_SRL:   w_res = bus.op_b >> w_shamt;
         C_SRA:   w_res = $unsigned($signed(bus.op_b) >>> w_shamt);
         default: w_res = '0;
      endcase
   end

   always_comb begin
      w_step = {r_shreg[WIDTH-2:0], 1'b0};
      case (r_sctl)
         C_SRL:   w_step = {1'b0, r_shreg[WIDTH-1:1]};
         C_SRA:   w_step = {r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};
         default: w_step = {r_shreg[WIDTH-2:0], 1'b0};
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_shreg  <= '0;
         r_cnt    <= 5'd0;
         r_sctl   <= 5'd0;
         r_result <= '0;
         r_zero   <= 1'b1;
         r_ovf    <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_serial) begin
                     r_shreg <= bus.op_b;
                     r_cnt   <= w_shamt;
                     r_sctl  <= bus.alu_ctl;
                     r_state <= SHIFT;
                  end else begin
                     r_result <= w_res;
                     r_zero   <= (w_res == '0);
                     r_ovf    <= w_ovf;
                     r_valid  <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               // Flush drops the shift silently; result keeps the last completed value.
               if (bus.flush) begin
                  r_cnt   <= 5'd0;
                  r_state <= IDLE;
               end else begin
                  r_shreg <= w_step;
                  r_cnt   <= r_cnt - 5'd1;
                  if (r_cnt == 5'd1) begin
                     r_result <= w_step;
                     r_zero   <= (w_step == '0);
                     r_ovf    <= 1'b0;
                     r_valid  <= 1'b1;
                     r_state  <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
